// File: rtl/servo_pkg.sv
// ---------------------------------------------------------------------------
// servo_pkg
//
// Shared widths, default timing constants and helpers for the hobby-servo
// PWM blocks.
//
// Contents:
//   US_W             width of any pulse width expressed in microseconds
//   FRAME_W          width of the microsecond position counter inside a frame
//   DEF_CLK_FREQ_HZ  default system clock frequency
//   DEF_PERIOD_US    default PWM frame length (50 Hz)
//   US_PER_SEC       microseconds per second, used to derive the prescaler
//   us_t / frame_t   convenience vector types for the two widths above
//   clamp_us()       saturate a requested width into a [lo, hi] window
// ---------------------------------------------------------------------------
package servo_pkg;

  localparam int US_W            = 11;
  localparam int FRAME_W         = 15;
  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_PERIOD_US   = 20000;
  localparam int US_PER_SEC      = 1_000_000;

  typedef logic [US_W-1:0]    us_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Saturate v into [lo, hi]. The upper bound is tested first. As a result,
  // a degenerate window (lo > hi) still produces a defined value.
  function automatic us_t clamp_us(input us_t v, input us_t lo, input us_t hi);
    us_t r;
    r = v;
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_us_tick.sv
// ---------------------------------------------------------------------------
// servo_us_tick
//
// Clock prescaler that produces a one-cycle strobe once every DIV clocks.
// The servo generator uses it as its 1 us time base. The steering axis can
// use it as well.
//
// Parameters:
//   DIV      clocks per strobe (clock frequency / 1 MHz for a 1 us tick)
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset; restarts the count at 0
//   us_tick  high in the last cycle of every DIV-cycle period
// ---------------------------------------------------------------------------
module servo_us_tick #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick
);

  // At least one bit is kept so that DIV == 1 still elaborates.
  // In that case the tick is then permanently high.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_pre_cnt;

  if (DIV < 1) begin : g_chk_div
    $error("servo_us_tick: DIV must be at least 1");
  end

  // Free-running 0..DIV-1 counter. Reset puts it back to 0, so the first
  // strobe after reset comes exactly DIV cycles after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (r_pre_cnt == LAST_CNT) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  assign us_tick = (r_pre_cnt == LAST_CNT);

endmodule

// File: rtl/servo_pwm_slew.sv
// ---------------------------------------------------------------------------
// servo_pwm_slew
//
// Slew-limited hobby-servo PWM generator. It accepts a requested pulse width
// in microseconds and clamps it to the safe servo window. At each frame
// boundary, the emitted width moves toward the request by at most SLEW_US.
// The output is a PWM frame whose width and enable change only at frame
// boundaries. A frame that has started always completes with the width and
// enable it latched, so runt pulses cannot occur.
//
// Parameters:
//   CLK_FREQ_HZ  system clock, an integer multiple of 1 MHz
//   PERIOD_US    frame length in microseconds
//   MIN_US       lowest pulse width ever emitted
//   MAX_US       highest pulse width ever emitted (< 2048, < PERIOD_US)
//   CENTER_US    pulse width after reset, inside [MIN_US, MAX_US]
//   SLEW_US      largest width change per frame; 0 removes the limit
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   target_us    requested width, sampled only on the frame-boundary cycle
//   en           output enable, sampled only on the frame-boundary cycle
//   pwm          registered servo PWM output
//   frame_start  one-cycle pulse in the first cycle of each new frame
//   cur_us       width currently being emitted
//   settled      cur_us equals the clamped target taken at the last boundary
// ---------------------------------------------------------------------------
module servo_pwm_slew
  import servo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int PERIOD_US   = DEF_PERIOD_US,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int CENTER_US   = 1500,
  parameter int SLEW_US     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [US_W-1:0] target_us,
  input  logic            en,
  output logic            pwm,
  output logic            frame_start,
  output logic [US_W-1:0] cur_us,
  output logic            settled
);

  localparam int DIV    = CLK_FREQ_HZ / US_PER_SEC;
  localparam int DIFF_W = US_W + 1;

  // Any step of 2048 or more can never be reached, because the clamped
  // difference is always below 2048. Such a step is therefore handled the
  // same way as "no limit". This also keeps the 12-bit step constant from
  // silently truncating a large parameter.
  localparam int SLEW_EFF = (SLEW_US >= (1 << US_W)) ? 0 : SLEW_US;

  localparam us_t              MIN_W      = us_t'(MIN_US);
  localparam us_t              MAX_W      = us_t'(MAX_US);
  localparam us_t              CENTER_W   = us_t'(CENTER_US);
  localparam us_t              SLEW_STEP  = us_t'(SLEW_EFF);
  localparam logic [DIFF_W-1:0] SLEW_LIMIT = DIFF_W'(SLEW_EFF);
  localparam frame_t           FRAME_LAST = frame_t'(PERIOD_US - 1);

  // Elaboration-time sanity checks on the parameter set.
  if ((CLK_FREQ_HZ < US_PER_SEC) || ((CLK_FREQ_HZ % US_PER_SEC) != 0)) begin : g_chk_clk
    $error("servo_pwm_slew: CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
  end
  if ((PERIOD_US < 1) || (PERIOD_US > (1 << FRAME_W))) begin : g_chk_period
    $error("servo_pwm_slew: PERIOD_US does not fit the frame counter");
  end
  if ((MAX_US >= (1 << US_W)) || (MAX_US >= PERIOD_US)) begin : g_chk_max
    $error("servo_pwm_slew: MAX_US must be below 2048 and below PERIOD_US");
  end
  if ((MIN_US < 0) || (MIN_US > CENTER_US) || (CENTER_US > MAX_US)) begin : g_chk_center
    $error("servo_pwm_slew: need 0 <= MIN_US <= CENTER_US <= MAX_US");
  end
  if (SLEW_US < 0) begin : g_chk_slew
    $error("servo_pwm_slew: SLEW_US must not be negative");
  end

  logic                     w_us_tick;
  logic                     w_fb;
  us_t                      w_tgt_c;
  logic signed [DIFF_W-1:0] w_diff;
  logic        [DIFF_W-1:0] w_abs_diff;
  us_t                      w_next_cur;

  frame_t r_us_cnt;
  us_t    r_cur_us;
  logic   r_act;
  logic   r_pwm;
  logic   r_frame_start;
  logic   r_settled;

  servo_us_tick #(
    .DIV (DIV)
  ) u_us_tick (
    .clk     (clk),
    .rst     (rst),
    .us_tick (w_us_tick)
  );

  // The frame boundary is the very last clock of the last microsecond.
  // Everything that is latched per frame changes on this one cycle.
  assign w_fb    = w_us_tick && (r_us_cnt == FRAME_LAST);
  assign w_tgt_c = clamp_us(target_us, MIN_W, MAX_W);

  // Next width for the coming frame. The difference is taken signed and one
  // bit wider than a width, so it can express -2047..+2047. Its magnitude is
  // compared with the step to decide between a full jump and a limited step.
  // A limited step can never overshoot, because it is used only when the
  // distance is larger than the step.
  always_comb begin
    w_diff     = $signed({1'b0, w_tgt_c}) - $signed({1'b0, r_cur_us});
    w_abs_diff = w_diff[DIFF_W-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_next_cur = w_tgt_c;
    if ((SLEW_EFF != 0) && (w_abs_diff > SLEW_LIMIT)) begin
      if (w_diff[DIFF_W-1]) begin
        w_next_cur = r_cur_us - SLEW_STEP;
      end else begin
        w_next_cur = r_cur_us + SLEW_STEP;
      end
    end
  end

  // Microsecond position inside the frame. It advances on each prescaler
  // tick and wraps on the boundary, so a reset restarts the frame at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_us_cnt <= '0;
    end else if (w_us_tick) begin
      if (w_fb) begin
        r_us_cnt <= '0;
      end else begin
        r_us_cnt <= r_us_cnt + 1'b1;
      end
    end
  end

  // Per-frame state is latched only on the boundary. Because of this, width
  // and enable stay fixed for a whole frame whatever the inputs do
  // mid-frame. The frame_start output is simply the boundary delayed by one
  // register. It therefore marks the first cycle of the frame that begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_us      <= CENTER_W;
      r_act         <= 1'b1;
      r_settled     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_fb;
      if (w_fb) begin
        r_cur_us  <= w_next_cur;
        r_settled <= (w_next_cur == w_tgt_c);
        r_act     <= en;
      end
    end
  end

  // The pulse is high while the frame position is below the latched width.
  // Because the position holds for DIV clocks per microsecond, the high
  // time is exactly cur_us*DIV cycles. On the boundary cycle the position is
  // PERIOD_US-1, which is above any legal width. The output is therefore
  // always low when a new width takes over.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= r_act && (r_us_cnt < frame_t'(r_cur_us));
    end
  end

  assign pwm         = r_pwm;
  assign frame_start = r_frame_start;
  assign cur_us      = r_cur_us;
  assign settled     = r_settled;

endmodule
